// File: rtl/trip_supervisor.sv
// Drive supervisor: a filtered thermal shutdown/cooldown FSM feeding a trip FSM.
// Actuator outputs are registered from next-state so they change together on one edge.
module trip_supervisor #(
  parameter int HOT_CYCLES  = 4,
  parameter int COOL_CYCLES = 16,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             start_trip,
  input  logic             arrived,
  input  logic             gas_tank_empty,
  input  logic             cpu_overheated,
  output logic             keep_driving,
  output logic             shut_off_computer,
  output logic             trip_done,
  output logic [2:0]       drive_state,
  output logic [CNT_W-1:0] shutdown_count
);

  // thermal  | meaning
  // COOL     | computer on, counting consecutive overheat samples
  // SHUTDOWN | computer off, still overheated
  // COOLDOWN | computer off, counting consecutive cool samples
  // trip     | meaning
  // IDLE     | waiting for start_trip
  // DRIVE    | driving
  // REFUEL   | stopped for fuel
  // PAUSE    | stopped while computer is off
  // DONE     | destination reached, waiting for arrived to drop

  typedef enum logic [1:0] {TH_COOL, TH_SHUTDOWN, TH_COOLDOWN} therm_t;
  typedef enum logic [2:0] {
    TR_IDLE   = 3'd0,
    TR_DRIVE  = 3'd1,
    TR_REFUEL = 3'd2,
    TR_PAUSE  = 3'd3,
    TR_DONE   = 3'd4
  } trip_t;

  localparam int HW = $clog2(HOT_CYCLES + 1);
  localparam int CW = $clog2(COOL_CYCLES + 1);
  localparam logic [31:0] HOT_U  = HOT_CYCLES;
  localparam logic [31:0] COOL_U = COOL_CYCLES;

  therm_t          therm, therm_nxt;
  trip_t           trip, trip_nxt;
  logic [HW-1:0]   hot_cnt, hot_nxt;
  logic [CW-1:0]   cool_cnt, cool_nxt;
  logic            count_inc;
  logic            therm_ok;

  always_comb begin
    therm_nxt = therm;
    hot_nxt   = hot_cnt;
    cool_nxt  = cool_cnt;
    count_inc = 1'b0;
    case (therm)
      TH_COOL: begin
        if (cpu_overheated) begin
          if (32'(hot_cnt) + 32'd1 >= HOT_U) begin
            therm_nxt = TH_SHUTDOWN;
            hot_nxt   = '0;
            count_inc = 1'b1;
          end else begin
            hot_nxt = hot_cnt + HW'(1);
          end
        end else begin
          hot_nxt = '0;
        end
      end
      TH_SHUTDOWN: begin
        // The low sample that leaves SHUTDOWN is the first of the cool streak.
        if (!cpu_overheated) begin
          cool_nxt = '0;
          if (COOL_U == 32'd1) therm_nxt = TH_COOL;
          else                 therm_nxt = TH_COOLDOWN;
        end
      end
      TH_COOLDOWN: begin
        if (cpu_overheated) begin
          therm_nxt = TH_SHUTDOWN;
          cool_nxt  = '0;
        end else if (32'(cool_cnt) + 32'd2 >= COOL_U) begin
          therm_nxt = TH_COOL;
          cool_nxt  = '0;
        end else begin
          cool_nxt = cool_cnt + CW'(1);
        end
      end
      default: begin
        therm_nxt = TH_COOL;
        hot_nxt   = '0;
        cool_nxt  = '0;
      end
    endcase
  end

  assign therm_ok = (therm_nxt == TH_COOL);

  always_comb begin
    trip_nxt = trip;
    case (trip)
      TR_IDLE:
        if (start_trip && !arrived && !gas_tank_empty && therm_ok) trip_nxt = TR_DRIVE;
      TR_DRIVE:
        if (arrived)             trip_nxt = TR_DONE;
        else if (gas_tank_empty) trip_nxt = TR_REFUEL;
        else if (!therm_ok)      trip_nxt = TR_PAUSE;
      TR_REFUEL:
        if (arrived)              trip_nxt = TR_DONE;
        else if (!gas_tank_empty) trip_nxt = therm_ok ? TR_DRIVE : TR_PAUSE;
      TR_PAUSE:
        if (arrived)             trip_nxt = TR_DONE;
        else if (gas_tank_empty) trip_nxt = TR_REFUEL;
        else if (therm_ok)       trip_nxt = TR_DRIVE;
      TR_DONE:
        if (!arrived) trip_nxt = TR_IDLE;
      default:
        trip_nxt = TR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      therm             <= TH_COOL;
      trip              <= TR_IDLE;
      hot_cnt           <= '0;
      cool_cnt          <= '0;
      shutdown_count    <= '0;
      keep_driving      <= 1'b0;
      shut_off_computer <= 1'b0;
      trip_done         <= 1'b0;
      drive_state       <= 3'd0;
    end else begin
      therm             <= therm_nxt;
      trip              <= trip_nxt;
      hot_cnt           <= hot_nxt;
      cool_cnt          <= cool_nxt;
      if (count_inc && (shutdown_count != '1))
        shutdown_count <= shutdown_count + CNT_W'(1);
      keep_driving      <= (trip_nxt == TR_DRIVE);
      shut_off_computer <= (therm_nxt != TH_COOL);
      trip_done         <= (trip_nxt == TR_DONE);
      drive_state       <= trip_nxt;
    end
  end

endmodule
